des_pack: RTL and testbench

Parametrised input-word packer: collects `WORDS` consecutive `DIN_W`-bit input slices, qualified by a valid strobe, into one `OUT_W`-bit output word. It announces each completed word with a one-cycle write-enable pulse for the downstream memory/FIFO write port. It adds the following over the fixed 13→40 deserializer:
- input qualification;
- selectable slice order;
- an explicit flush for partial words;
- a slice-count tag;
- synchronous reset.

It sits between the serial/narrow acquisition front end and the wide storage write port.

---
 rtl/des_pack.sv | 95 +++++++++
 tb/tb_des_pack.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/des_pack.sv
// Input-word packer: gathers WORDS valid DIN_W-bit slices into one OUT_W-bit word and
// pulses WE when a word is emitted. Flush emits a partial word with its unfilled slots cleared.
module des_pack #(
  parameter int DIN_W     = 13,
  parameter int WORDS     = 3,
  parameter int OUT_W     = 40,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       Cin,
  input  logic                       RSTn,
  input  logic [DIN_W-1:0]           Din,
  input  logic                       Vin,
  input  logic                       Flush,
  output logic [OUT_W-1:0]           Dout,
  output logic                       WE,
  output logic [$clog2(WORDS+1)-1:0] Len,
  output logic [$clog2(WORDS)-1:0]   cnt
);

  localparam int ACC_W = DIN_W * WORDS;
  localparam int CNT_W = $clog2(WORDS);
  localparam int LEN_W = $clog2(WORDS + 1);

  generate
    if (OUT_W < ACC_W) begin : g_bad_width
      $error("des_pack: OUT_W must be at least DIN_W*WORDS");
    end
  endgenerate

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             we_q, we_d;
  logic [ACC_W-1:0] merged;
  logic             complete;

  // Each slot takes Din only when it is the slot addressed by the current arrival index.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_slot
      localparam int K = LSB_FIRST ? gi : (WORDS - 1 - gi);
      assign merged[gi*DIN_W +: DIN_W] =
        (Vin && (cnt_q == CNT_W'(K))) ? Din : acc_q[gi*DIN_W +: DIN_W];
    end
  endgenerate

  assign complete = Vin && (cnt_q == CNT_W'(WORDS - 1));

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    len_d  = len_q;
    we_d   = 1'b0;
    if (complete) begin
      dout_d = OUT_W'(merged);
      len_d  = LEN_W'(WORDS);
      we_d   = 1'b1;
      acc_d  = '0;
      cnt_d  = '0;
    end else if (Flush && ((cnt_q != '0) || Vin)) begin
      // Slots never written since the last clear are still zero, so no masking is needed.
      dout_d = OUT_W'(merged);
      len_d  = LEN_W'(cnt_q) + LEN_W'(Vin);
      we_d   = 1'b1;
      acc_d  = '0;
      cnt_d  = '0;
    end else if (Vin) begin
      acc_d = merged;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Cin) begin
    if (!RSTn) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      len_q  <= '0;
      we_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      len_q  <= len_d;
      we_q   <= we_d;
    end
  end

  assign Dout = dout_q;
  assign WE   = we_q;
  assign Len  = len_q;
  assign cnt  = cnt_q;

endmodule

// File: tb/tb_des_pack.sv
// Bench for des_pack: both slice orders driven from one stimulus stream, checked every cycle
// against a queue-based word model, plus literal expectations for the directed cases.
module tb_des_pack;

  localparam int DW = 13;
  localparam int NW = 3;
  localparam int OW = 40;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] din = '0;
  logic          vin = 1'b0;
  logic          flush = 1'b0;

  logic [OW-1:0] dout1, dout0;
  logic          we1, we0;
  logic [1:0]    len1, len0;
  logic [1:0]    cnt1, cnt0;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model state: slices of the word in progress, plus the expected registered outputs.
  int            pend[$];
  bit            exp_we = 1'b0;
  int            exp_len = 0;
  logic [OW-1:0] exp_d1 = '0;
  logic [OW-1:0] exp_d0 = '0;

  always #5 clk = ~clk;

  des_pack #(.DIN_W(DW), .WORDS(NW), .OUT_W(OW), .LSB_FIRST(1'b1)) dut_lsb (
    .Cin(clk), .RSTn(rstn), .Din(din), .Vin(vin), .Flush(flush),
    .Dout(dout1), .WE(we1), .Len(len1), .cnt(cnt1)
  );

  des_pack #(.DIN_W(DW), .WORDS(NW), .OUT_W(OW), .LSB_FIRST(1'b0)) dut_msb (
    .Cin(clk), .RSTn(rstn), .Din(din), .Vin(vin), .Flush(flush),
    .Dout(dout0), .WE(we0), .Len(len0), .cnt(cnt0)
  );

  function automatic logic [OW-1:0] build(input int q[$], input bit lsb);
    logic [63:0] w = 0;
    for (int k = 0; k < q.size(); k++) begin
      int s = lsb ? k : (NW - 1 - k);
      w = w + (64'(q[k]) << (s * DW));
    end
    return w[OW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic emit();
    exp_we  = 1'b1;
    exp_len = pend.size();
    exp_d1  = build(pend, 1'b1);
    exp_d0  = build(pend, 1'b0);
    pend.delete();
  endtask

  task automatic model(input bit r, input bit v, input logic [DW-1:0] d, input bit f);
    exp_we = 1'b0;
    if (!r) begin
      pend.delete();
      exp_len = 0;
      exp_d1  = '0;
      exp_d0  = '0;
    end else if (v && pend.size() == NW - 1) begin
      pend.push_back(int'(d));
      emit();
    end else if (f && (pend.size() > 0 || v)) begin
      if (v) pend.push_back(int'(d));
      emit();
    end else if (v) begin
      pend.push_back(int'(d));
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [DW-1:0] d, input bit f);
    rstn = r; vin = v; din = d; flush = f;
    @(posedge clk);
    model(r, v, d, f);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("we_lsb",   64'(we1),   64'(exp_we));
      chk("we_msb",   64'(we0),   64'(exp_we));
      chk("dout_lsb", 64'(dout1), 64'(exp_d1));
      chk("dout_msb", 64'(dout0), 64'(exp_d0));
      chk("len_lsb",  64'(len1),  64'(exp_len));
      chk("len_msb",  64'(len0),  64'(exp_len));
      chk("cnt_lsb",  64'(cnt1),  64'(pend.size()));
      chk("cnt_msb",  64'(cnt0),  64'(pend.size()));
    end
  end

  initial begin
    int we_seen;
    step(0, 1, 13'h1555, 1);
    step(0, 0, '0, 0);
    chk_en = 1'b1;
    chk("rst_dout", 64'(dout1), 64'h0);
    chk("rst_we",   64'(we1),   64'h0);
    chk("rst_len",  64'(len1),  64'h0);
    chk("rst_cnt",  64'(cnt1),  64'h0);

    // Defaults: three slices, both orders
    step(1, 1, 13'h0001, 0);
    step(1, 1, 13'h1FFF, 0);
    chk("dflt_no_early_we", 64'(we1), 64'h0);
    step(1, 1, 13'h0AAA, 0);
    chk("dflt_we",     64'(we1),   64'h1);
    chk("dflt_dout",   64'(dout1), 64'h2A_ABFF_E001);
    chk("msb_dout",    64'(dout0), 64'h00_07FF_EAAA);
    chk("dflt_len",    64'(len1),  64'd3);
    chk("dflt_cnt",    64'(cnt1),  64'd0);
    step(1, 0, '0, 0);
    chk("dflt_pulse_end", 64'(we1),   64'h0);
    chk("dflt_hold",      64'(dout1), 64'h2A_ABFF_E001);

    // Continuous stream 1..9
    we_seen = 0;
    for (int i = 1; i <= 9; i++) begin
      step(1, 1, DW'(i), 0);
      if (we1) we_seen++;
      if (i % 3 == 0) chk("stream_we_cycle", 64'(we1), 64'h1);
    end
    chk("stream_pulses", 64'(we_seen), 64'd3);
    chk("stream_w3",     64'(dout1),   64'd7 | (64'd8 << 13) | (64'd9 << 26));

    // Partial flushes
    step(1, 1, 13'h1234, 0);
    step(1, 0, '0, 1);
    chk("pflush_we",    64'(we1),   64'h1);
    chk("pflush_len",   64'(len1),  64'd1);
    chk("pflush_dout",  64'(dout1), 64'h00_0000_1234);
    chk("pflush_msb",   64'(dout0), 64'h48_D000_0000);
    step(1, 1, 13'h0005, 0);
    step(1, 1, 13'h0006, 1);
    chk("pflush2_len",  64'(len1),  64'd2);
    chk("pflush2_dout", 64'(dout1), 64'h00_0000_C005);
    step(1, 0, '0, 1);
    chk("flush_idle_we",  64'(we1),  64'h0);
    chk("flush_idle_len", 64'(len1), 64'd2);

    // Flush on a completing slice
    step(1, 1, 13'h0011, 0);
    step(1, 1, 13'h0022, 0);
    step(1, 1, 13'h0033, 1);
    chk("coll_len", 64'(len1), 64'd3);
    step(1, 0, '0, 0);
    chk("coll_single", 64'(we1), 64'h0);

    // Reset mid-word
    step(1, 1, 13'h0101, 0);
    step(1, 1, 13'h0202, 0);
    step(0, 0, '0, 0);
    chk("midrst_we",   64'(we1),   64'h0);
    chk("midrst_dout", 64'(dout1), 64'h0);
    chk("midrst_cnt",  64'(cnt1),  64'h0);
    step(1, 1, 13'h0003, 0);
    step(1, 1, 13'h0004, 0);
    step(1, 1, 13'h0005, 0);
    chk("midrst_new", 64'(dout1), 64'd3 | (64'd4 << 13) | (64'd5 << 26));

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) != 0, $urandom_range(9) < 7,
           DW'($urandom), $urandom_range(9) == 0);
    end
    step(1, 0, '0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
